// File: rtl/regfile_pkg.sv
// Shared constants and arbiter state encoding for the register-file write path.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {IDLE, CLEAR} arb_state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Request side and register-file write side of the arbiter; master drives requests, slave is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W  = regfile_pkg::REG_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      clear_start;
  logic                      clear_busy;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr;
  logic [DATA_W-1:0]         rf_data;

  modport master (
    output req_valid, req_addr, req_data, clear_start,
    input  req_ack, clear_busy, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, clear_start,
    output req_ack, clear_busy, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request at or above ptr_i, wrapping.
// Zero latency; found_o is low when no request is set.
module rr_priority_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]                     req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                     gnt_o,
  output logic                             found_o
);
  int idx;

  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port plus a zero-fill sweep; REGARB_ZERO_FILTER_EN drops r0 writes.
// Ack is combinational, the write lands on rf_* one edge later; losers and sweep-blocked requesters just hold valid.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W   = regfile_pkg::REG_DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  import regfile_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`ifdef REGARB_ZERO_FILTER_EN
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;
`endif

  arb_state_t          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic [NUM_REQ-1:0]  gnt, ack;
  logic                found;
  logic [PW-1:0]       win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_we;

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt),
    .found_o (found)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        win_idx  = PW'(k);
        win_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
        win_data = bus.req_data[k*DATA_W +: DATA_W];
      end
    end
    win_we = 1'b1;
`ifdef REGARB_ZERO_FILTER_EN
    win_we = (win_addr != '0);
`endif
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    ack       = '0;
    case (state_q)
      IDLE: begin
        // A clear request outranks any pending write; those writers simply wait.
        if (bus.clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = FIRST_ADDR;
        end else if (found) begin
          ack      = gnt;
          rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);
          if (win_we) begin
            rf_we_d   = 1'b1;
            rf_addr_d = win_addr;
            rf_data_d = win_data;
          end
        end
      end
      CLEAR: begin
        rf_we_d   = 1'b1;
        rf_addr_d = clr_cnt_q;
        rf_data_d = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign bus.req_ack    = reset ? '0 : ack;
  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_data    = rf_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random checks of the write-port arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int NR   = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
`ifdef REGARB_ZERO_FILTER_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  regfile_write_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREG)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: pointer as an integer, sweep as a queue of addresses still to write.
  int            m_ptr;
  int            m_sweep[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_ack;

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    int w;
    @(negedge clock);
    w = pick(bus.req_valid, m_ptr);
    m_ack = '0;
    if (!reset && m_sweep.size() == 0 && !bus.clear_start && w >= 0) m_ack[w] = 1'b1;
    chk("ack", 32'(bus.req_ack), 32'(m_ack));
    chk("rf_we", 32'(bus.rf_we), 32'(m_we));
    chk("rf_addr", 32'(bus.rf_addr), 32'(m_addr));
    chk("rf_data", bus.rf_data, m_data);
    chk("clear_busy", 32'(bus.clear_busy), 32'(m_sweep.size() != 0));
  endtask

  task automatic advance();
    int            w;
    logic [AW-1:0] a;
    logic          drop;
    if (reset) begin
      m_ptr = 0; m_sweep.delete(); m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_sweep.size() != 0) begin
      m_we = 1'b1; m_addr = AW'(m_sweep.pop_front()); m_data = '0;
    end else if (bus.clear_start) begin
      m_we = 1'b0;
      for (int r = FIRST; r < NREG; r++) m_sweep.push_back(r);
    end else begin
      w = pick(bus.req_valid, m_ptr);
      m_we = 1'b0;
      if (w >= 0) begin
        m_ptr = (w + 1) % NR;
        a = bus.req_addr[w*AW +: AW];
        drop = 1'b0;
`ifdef REGARB_ZERO_FILTER_EN
        drop = (a == '0);
`endif
        if (!drop) begin
          m_we = 1'b1; m_addr = a; m_data = bus.req_data[w*DW +: DW];
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, wr_n, first_a, last_a;
    logic done, got;

    reset = 1'b1;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.clear_start = 1'b0;
    advance();
    sample();
    chk("reset_we", 32'(bus.rf_we), 32'd0);
    chk("reset_busy", 32'(bus.clear_busy), 32'd0);
    chk("reset_addr", 32'(bus.rf_addr), 32'd0);
    advance();
    reset = 1'b0;

    // Single write, one-cycle latency.
    set_req(0, 5'd3, 32'hDEADBEEF);
    sample(); chk("single_ack", 32'(bus.req_ack), 32'd1);
    advance(); bus.req_valid = '0;
    sample();
    chk("single_we", 32'(bus.rf_we), 32'd1);
    chk("single_addr", 32'(bus.rf_addr), 32'd3);
    chk("single_data", bus.rf_data, 32'hDEADBEEF);
    advance();
    sample(); chk("single_we_drop", 32'(bus.rf_we), 32'd0);
    reset = 1'b1; advance(); reset = 1'b0;

    // Two requesters held for four cycles alternate.
    set_req(0, 5'd1, 32'h1111); set_req(1, 5'd2, 32'h2222);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus.req_valid = '0;
      sample();
      if (k < 4) chk("b2b_ack", 32'(bus.req_ack), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk("b2b_we", 32'(bus.rf_we), 32'd1);
        chk("b2b_addr", 32'(bus.rf_addr), (k % 2 == 1) ? 32'd1 : 32'd2);
      end
      advance();
    end

    // Full clear sweep from idle.
    bus.clear_start = 1'b1;
    sample(); chk("clr_start_ack", 32'(bus.req_ack), 32'd0);
    advance(); bus.clear_start = 1'b0;
    busy_n = 0; wr_n = 0; first_a = -1; last_a = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      sample();
      if (bus.clear_busy) busy_n++;
      if (bus.rf_we) begin
        if (first_a < 0) first_a = int'(bus.rf_addr);
        last_a = int'(bus.rf_addr);
        wr_n++;
      end
      if (!bus.clear_busy && !bus.rf_we) done = 1'b1;
      advance();
    end
    chk("clr_done", 32'(done), 32'd1);
    chk("clr_busy_cycles", 32'(busy_n), 32'(NREG - FIRST));
    chk("clr_writes", 32'(wr_n), 32'(NREG - FIRST));
    chk("clr_first_addr", 32'(first_a), 32'(FIRST));
    chk("clr_last_addr", 32'(last_a), 32'(NREG - 1));

    // Clear beats a simultaneous request, which is served afterwards.
    set_req(1, 5'd7, 32'h12345678); bus.clear_start = 1'b1;
    sample(); chk("clr_vs_req_ack", 32'(bus.req_ack), 32'd0);
    advance(); bus.clear_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      sample();
      if (!bus.clear_busy) begin
        got = 1'b1;
        chk("post_clr_ack", 32'(bus.req_ack), 32'd2);
      end
      advance();
    end
    chk("post_clr_seen", 32'(got), 32'd1);
    bus.req_valid = '0;
    sample();
    chk("post_clr_we", 32'(bus.rf_we), 32'd1);
    chk("post_clr_addr", 32'(bus.rf_addr), 32'd7);
    advance();

    // Reset in mid-sweep.
    bus.clear_start = 1'b1; advance(); bus.clear_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      sample();
      if (bus.rf_we && bus.rf_addr == 5'd9) begin got = 1'b1; reset = 1'b1; end
      advance();
    end
    chk("mid_reset_seen", 32'(got), 32'd1);
    reset = 1'b0;
    set_req(2, 5'd5, 32'hA5A5A5A5);
    sample();
    chk("mid_reset_we", 32'(bus.rf_we), 32'd0);
    chk("mid_reset_busy", 32'(bus.clear_busy), 32'd0);
    chk("mid_reset_ack", 32'(bus.req_ack), 32'd4);
    advance(); bus.req_valid = '0;
    sample();
    chk("mid_reset_addr", 32'(bus.rf_addr), 32'd5);
    chk("mid_reset_data", bus.rf_data, 32'hA5A5A5A5);
    advance();

    // Register 0 handling.
    set_req(0, 5'd0, 32'hFFFF0000);
    sample(); chk("r0_ack", 32'(bus.req_ack), 32'd1);
    advance(); bus.req_valid = '0;
    sample();
`ifdef REGARB_ZERO_FILTER_EN
    chk("r0_we_filtered", 32'(bus.rf_we), 32'd0);
`else
    chk("r0_we", 32'(bus.rf_we), 32'd1);
    chk("r0_addr", 32'(bus.rf_addr), 32'd0);
`endif
    advance();

    // Random traffic: requesters hold until acked, occasional clears and resets.
    for (int c = 0; c < 600; c++) begin
      bus.clear_start = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 299) == 0);
      sample();
      advance();
      for (int i = 0; i < NR; i++) begin
        if (m_ack[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 9) < (m_ack[i] ? 5 : 3))
            set_req(i, AW'($urandom_range(0, NREG - 1)), $urandom);
          else
            bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.clear_start = 1'b0; reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between NUM_REQ requesters using round-robin arbitration with a valid/ack handshake. Also runs a hardware clear sequence that writes zero to every register, one per cycle. Sits between the writeback sources (ALU writeback, multdiv completion, ...) and the register file's ctrl_writeEnable/ctrl_writeReg/data_writeReg inputs. All rf_* outputs are registered on the rising edge, so they are stable when the negative-edge register flops capture them.

Parameters:
NUM_REQ, 2, number of write requesters (>=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers swept by the clear sequence (<= 2**ADDR_W)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request; held until acked
req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ack  output  NUM_REQ  one-hot accept, combinational, same cycle as capture
clear_start  input  1  single-cycle pulse that starts the clear sweep
clear_busy  output  1  high while a clear sweep is in progress
rf_we  output  1  register-file write enable (registered)
rf_addr  output  ADDR_W  register-file write address (registered)
rf_data  output  DATA_W  register-file write data (registered)

Behaviour:
- Reset: synchronous, active-high; takes priority over everything else, including mid-sweep.
  - State=IDLE; rr_ptr=0; clear counter=0.
  - rf_we=0, rf_addr=0, rf_data=0, clear_busy=0, req_ack=0.
- States: IDLE, CLEAR.
- IDLE, clear_start=0:
  - Grant the first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Assert req_ack for the winner only, in that same cycle.
  - Next edge: rf_we=1, rf_addr/rf_data = the winner's fields; rr_ptr = winner+1 (wraps to 0).
  - No valid requester: rf_we=0 next edge; rf_addr, rf_data and rr_ptr hold.
- Latency and throughput: request accepted in cycle N appears on rf_* in cycle N+1. One write per cycle, back-to-back.
- Requester rule: after its ack, the requester deasserts valid or presents a new request next cycle. A held valid is treated as a new request.
- IDLE, clear_start=1:
  - Clear beats requests: no ack that cycle.
  - Next edge: state=CLEAR, clear_busy=1, counter=0.
  - Pending requests stay pending and are served after the sweep.
- CLEAR:
  - Each edge: rf_we=1, rf_addr=counter, rf_data=0, then counter+1.
  - The edge that issues address NUM_REGS-1 returns to IDLE with clear_busy=0.
  - Total of NUM_REGS write cycles.
  - req_ack=0 throughout; clear_start is ignored.
- rf_we deasserts on the cycle after the last write unless a grant follows.
- rr_ptr is not changed by the clear sequence.

Optional Feature:
REGARB_ZERO_FILTER_EN
- Defined:
  - A request addressed to register 0 is still acked and rr_ptr still advances, but rf_we=0 for that slot.
  - The clear sweep starts at address 1 and takes NUM_REGS-1 cycles.
- Undefined: address 0 is written like any other register; the sweep starts at 0.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32;
  - state enum arb_state_t {IDLE, CLEAR}.
- One sub-module: rr_priority_pick (parameter N). Combinational round-robin picker from a request vector and pointer; outputs a one-hot grant and a found flag. The FSM, clear counter and output registers stay in the top.

Test Plan:
- Reset then req_valid=01, addr0=3, data0=0xDEADBEEF: req_ack=01 same cycle; next cycle rf_we=1, rf_addr=3, rf_data=0xDEADBEEF; following cycle rf_we=0.
- req_valid=11 held for 4 cycles, addr0=1, addr1=2: acks 01,10,01,10; rf_addr sequence 1,2,1,2 with rf_we=1 every cycle.
- clear_start pulse from IDLE: clear_busy=1 for 32 cycles; rf_addr 0..31 with rf_data=0 and rf_we=1; clear_busy=0 and rf_we=0 on cycle 33.
- clear_start together with req_valid=10 (addr=7): no ack during the sweep; after the sweep req_ack=10; next cycle rf_addr=7.
- reset asserted at sweep cycle 10 (rf_addr=9): next edge rf_we=0, clear_busy=0, state IDLE; a fresh request is served normally.
- With REGARB_ZERO_FILTER_EN, request to addr 0: req_ack=1 and rf_we stays 0; clear sweep issues addresses 1..31 only (31 cycles).
